// File: rtl/mips_mem_pkg.sv
// ============================================================================
//  mips_mem_pkg
//  Shared types and width helpers for the unified-memory port arbiter.
//  Revision: 1.0
// ============================================================================
`default_nettype none

package mips_mem_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

    typedef enum logic {
        GNT_IF = 1'b0,
        GNT_D  = 1'b1
    } grant_t;

    // Bits needed to hold 0..maxval, never less than one.
    function automatic int cnt_width(input int maxval);
        return (maxval > 1) ? $clog2(maxval + 1) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mem_port_arbiter_if.sv
// ============================================================================
//  mem_port_arbiter_if
//  Fetch, data and memory-side signals of the port arbiter.
//  Revision: 1.0
// ============================================================================
`default_nettype none

interface mem_port_arbiter_if;
    import mips_mem_pkg::*;

    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_done;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [DATA_W-1:0] d_rdata;
    logic              d_done;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    logic              stall_if;
    logic              stall_d;

    // Arbiter side
    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output if_rdata, if_done, d_rdata, d_done,
        output mem_req, mem_we, mem_addr, mem_wdata,
        output stall_if, stall_d
    );

    // Pipeline ports and memory side
    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  if_rdata, if_done, d_rdata, d_done,
        input  mem_req, mem_we, mem_addr, mem_wdata,
        input  stall_if, stall_d
    );

endinterface

`default_nettype wire

// File: rtl/mem_arb_pick.sv
// ============================================================================
//  mem_arb_pick
//  Combinational grant picker: data port first unless IF has been starved.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module mem_arb_pick
    import mips_mem_pkg::*;
#(
    parameter int STARVE_MAX = 4,
    parameter int CNT_W      = 3
) (
    input  logic             if_req,
    input  logic             d_req,
    input  logic [CNT_W-1:0] starve_cnt,
    output grant_t           grant,
    output logic             valid
);

    always_comb begin
        valid = if_req | d_req;
        grant = GNT_D;
        if (if_req && (!d_req || (starve_cnt == CNT_W'(STARVE_MAX)))) begin
            grant = GNT_IF;
        end
    end

endmodule

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ============================================================================
//  mem_port_arbiter
//  Shares one fixed-latency single-port memory between fetch and data ports.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module mem_port_arbiter
    import mips_mem_pkg::*;
#(
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic               clk,
    input  logic               reset,
    mem_port_arbiter_if.slave  bus
);

    localparam int WAIT_W   = cnt_width(MEM_LAT - 1);
    localparam int STARVE_W = cnt_width(STARVE_MAX);

    arb_state_t          r_state;
    arb_state_t          w_next_state;
    grant_t              r_grant;
    logic                r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [WAIT_W-1:0]   r_wait_cnt;
    logic [STARVE_W-1:0] r_starve_cnt;
    logic [DATA_W-1:0]   r_if_rdata;
    logic [DATA_W-1:0]   r_d_rdata;

    grant_t              w_pick_grant;
    logic                w_pick_valid;
    logic                w_grant_now;
    logic                w_capture;

    mem_arb_pick #(
        .STARVE_MAX (STARVE_MAX),
        .CNT_W      (STARVE_W)
    ) u_pick (
        .if_req     (bus.if_req),
        .d_req      (bus.d_req),
        .starve_cnt (r_starve_cnt),
        .grant      (w_pick_grant),
        .valid      (w_pick_valid)
    );

    assign w_grant_now = (r_state == IDLE) && w_pick_valid;
    assign w_capture   = (r_state == WAIT) && (r_wait_cnt == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_pick_valid) w_next_state = ISSUE;
            ISSUE:   w_next_state = r_we ? RESP : WAIT;
            WAIT:    if (r_wait_cnt == '0) w_next_state = RESP;
            RESP:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_grant    <= GNT_IF;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_wait_cnt <= '0;
            r_if_rdata <= '0;
            r_d_rdata  <= '0;
        end else begin
            // Address and write data are frozen at grant; later port changes are ignored.
            if (w_grant_now) begin
                r_grant <= w_pick_grant;
                if (w_pick_grant == GNT_D) begin
                    r_we    <= bus.d_we;
                    r_addr  <= bus.d_addr;
                    r_wdata <= bus.d_wdata;
                end else begin
                    r_we    <= 1'b0;
                    r_addr  <= bus.if_addr;
                end
            end

            if (r_state == ISSUE) begin
                r_wait_cnt <= WAIT_W'(MEM_LAT - 1);
            end else if ((r_state == WAIT) && (r_wait_cnt != '0)) begin
                r_wait_cnt <= r_wait_cnt - 1'b1;
            end

            if (w_capture) begin
                if (r_grant == GNT_IF) begin
                    r_if_rdata <= bus.mem_rdata;
                end else begin
                    r_d_rdata  <= bus.mem_rdata;
                end
            end
        end
    end

    // Counts data grants taken while fetch is waiting; saturates at STARVE_MAX.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_starve_cnt <= '0;
        end else if (!bus.if_req) begin
            r_starve_cnt <= '0;
        end else if (w_grant_now) begin
            if (w_pick_grant == GNT_IF) begin
                r_starve_cnt <= '0;
            end else if (r_starve_cnt != STARVE_W'(STARVE_MAX)) begin
                r_starve_cnt <= r_starve_cnt + 1'b1;
            end
        end
    end

    assign bus.mem_req   = (r_state == ISSUE);
    assign bus.mem_we    = (r_state == ISSUE) && r_we;
    assign bus.mem_addr  = r_addr;
    assign bus.mem_wdata = r_wdata;

    assign bus.if_done   = (r_state == RESP) && (r_grant == GNT_IF);
    assign bus.d_done    = (r_state == RESP) && (r_grant == GNT_D);
    assign bus.if_rdata  = r_if_rdata;
    assign bus.d_rdata   = r_d_rdata;

    assign bus.stall_if  = bus.if_req && !bus.if_done;
    assign bus.stall_d   = bus.d_req  && !bus.d_done;

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
//  tb_mem_port_arbiter
//  Directed self-checking bench with a 2-cycle-latency memory model.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module tb_mem_port_arbiter;
    import mips_mem_pkg::*;

    localparam int MEM_LAT = 2;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   vectors     = 0;
    int   miscompares = 0;

    mem_port_arbiter_if bus ();

    mem_port_arbiter #(
        .MEM_LAT    (MEM_LAT),
        .STARVE_MAX (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [0:255];
    logic [31:0] rd_pipe;

    // Read data appears two cycles after the mem_req cycle.
    always @(posedge clk) begin
        if (reset) begin
            mem[16] <= 32'h2010_0005;
            mem[17] <= 32'h1111_2222;
            mem[18] <= 32'h4848_4848;
            mem[33] <= 32'hCAFE_F00D;
            mem[36] <= 32'h9000_0000;
            mem[37] <= 32'h9000_0001;
            mem[38] <= 32'h9000_0002;
            mem[39] <= 32'h9000_0003;
        end else if (bus.mem_req && bus.mem_we) begin
            mem[bus.mem_addr[9:2]] <= bus.mem_wdata;
        end
        rd_pipe       <= (bus.mem_req && !bus.mem_we) ? mem[bus.mem_addr[9:2]] : 32'hBAD0_BAD0;
        bus.mem_rdata <= rd_pipe;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    // Called in the IDLE cycle whose requests are already driven; returns in the done cycle.
    task automatic access(input string tag, input logic [31:0] addr, input logic we,
                          input logic is_if, input logic [31:0] data);
        int lat;
        lat = we ? 2 : MEM_LAT + 2;
        mid();
        chk({tag, " stall_idle"}, is_if ? bus.stall_if : bus.stall_d, 32'd1);
        chk({tag, " no_req_idle"}, bus.mem_req, 32'd0);
        cyc(); mid();
        chk({tag, " mem_req"}, bus.mem_req, 32'd1);
        chk({tag, " mem_addr"}, bus.mem_addr, addr);
        chk({tag, " mem_we"}, bus.mem_we, {31'd0, we});
        if (we) chk({tag, " mem_wdata"}, bus.mem_wdata, data);
        for (int k = 2; k < lat; k++) begin
            cyc(); mid();
            chk({tag, " early_done"}, is_if ? bus.if_done : bus.d_done, 32'd0);
        end
        cyc(); mid();
        chk({tag, " done"}, is_if ? bus.if_done : bus.d_done, 32'd1);
        chk({tag, " stall_in_done"}, is_if ? bus.stall_if : bus.stall_d, 32'd0);
        if (!we) chk({tag, " rdata"}, is_if ? bus.if_rdata : bus.d_rdata, data);
    endtask

    initial begin
        bus.if_req  = 1'b0;
        bus.if_addr = '0;
        bus.d_req   = 1'b0;
        bus.d_we    = 1'b0;
        bus.d_addr  = '0;
        bus.d_wdata = '0;

        // Reset state and idle behaviour
        repeat (2) cyc();
        mid();
        chk("rst mem_req", bus.mem_req, 32'd0);
        chk("rst dones", {30'd0, bus.if_done, bus.d_done}, 32'd0);
        chk("rst rdata", bus.if_rdata | bus.d_rdata, 32'd0);
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cyc(); mid();
            chk("t1 ctrl", {26'd0, bus.mem_req, bus.mem_we, bus.if_done, bus.d_done,
                            bus.stall_if, bus.stall_d}, 32'd0);
            chk("t1 data", bus.mem_addr | bus.mem_wdata | bus.if_rdata | bus.d_rdata, 32'd0);
        end

        // Single fetch
        cyc();
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h40;
        access("t2 if", 32'h40, 1'b0, 1'b1, 32'h2010_0005);
        cyc();
        bus.if_req = 1'b0;
        mid();
        chk("t2 done_pulse", bus.if_done, 32'd0);
        chk("t2 rdata_hold", bus.if_rdata, 32'h2010_0005);

        // Store then load back
        cyc();
        bus.d_req   = 1'b1;
        bus.d_we    = 1'b1;
        bus.d_addr  = 32'h80;
        bus.d_wdata = 32'hDEAD_BEEF;
        access("t3 st", 32'h80, 1'b1, 1'b0, 32'hDEAD_BEEF);
        chk("t3 st d_rdata", bus.d_rdata, 32'd0);
        cyc();
        bus.d_we = 1'b0;
        access("t3 ld", 32'h80, 1'b0, 1'b0, 32'hDEAD_BEEF);
        cyc();
        bus.d_req = 1'b0;

        // Simultaneous requests: data first, fetch at the following IDLE
        cyc();
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h44;
        bus.d_req   = 1'b1;
        bus.d_addr  = 32'h84;
        access("t4 d", 32'h84, 1'b0, 1'b0, 32'hCAFE_F00D);
        chk("t4 stall_if", bus.stall_if, 32'd1);
        cyc();
        bus.d_req = 1'b0;
        access("t4 if", 32'h44, 1'b0, 1'b1, 32'h1111_2222);
        cyc();
        bus.if_req = 1'b0;

        // Starvation: four data grants, then fetch is forced
        cyc();
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h48;
        bus.d_req   = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.d_addr = 32'h90 + 32'(4 * i);
            access("t5 d", 32'h90 + 32'(4 * i), 1'b0, 1'b0, 32'h9000_0000 + 32'(i));
            cyc();
        end
        bus.d_addr = 32'h84;
        access("t5 if forced", 32'h48, 1'b0, 1'b1, 32'h4848_4848);
        cyc();
        bus.if_addr = 32'h40;
        access("t5 d after", 32'h84, 1'b0, 1'b0, 32'hCAFE_F00D);
        cyc();
        bus.if_req = 1'b0;
        bus.d_req  = 1'b0;

        // Reset during WAIT of a load
        cyc();
        bus.d_req  = 1'b1;
        bus.d_addr = 32'h84;
        cyc();
        cyc(); mid();
        chk("t6 in_wait", {30'd0, dut.r_state}, {30'd0, WAIT});
        reset     = 1'b1;
        bus.d_req = 1'b0;
        #1;
        chk("t6 mem_req", bus.mem_req, 32'd0);
        chk("t6 d_done", bus.d_done, 32'd0);
        chk("t6 d_rdata", bus.d_rdata, 32'd0);
        chk("t6 state", {30'd0, dut.r_state}, {30'd0, IDLE});
        cyc();
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cyc(); mid();
            chk("t6 quiet", {30'd0, bus.mem_req, bus.d_done}, 32'd0);
        end
        cyc();
        bus.d_req  = 1'b1;
        bus.d_addr = 32'h80;
        access("t6 ld", 32'h80, 1'b0, 1'b0, 32'hDEAD_BEEF);
        cyc();
        bus.d_req = 1'b0;
        repeat (2) cyc();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
